// File: rtl/pio_clk_pulser_master.sv
// pio_clk_pulser_master
//
// Avalon-MM write master for a single-bit PIO output slave. It produces a
// programmed number of clock pulses on the slave's out_port by writing 1 and
// then 0 to the slave, with a programmable idle gap after each write.
//
// Optional build macro: PIO_PULSER_READBACK_EN
//   When defined, every accepted write is followed by a read of the slave.
//   If the level read back differs from the level written, the sticky error
//   flag is set and the train ends with the line forced low.
//
// Ports
//   clk              system clock, rising edge
//   reset            asynchronous, active-high
//   start            one-cycle request, honoured only in IDLE
//   abort            level; ends the train with the line low
//   pulse_count      number of pulses, captured on an accepted start
//   half_period      idle cycles after each accepted write, captured on start
//   busy             high from the cycle after an accepted start until DONE exits
//   done             one-cycle pulse when the train completes or is aborted
//   pulses_left      remaining pulses
//   avm_*            Avalon-MM master signals towards the PIO s1 port
//   avm_read_n       (readback build) active-low read
//   avm_readdata     (readback build) read data from the slave
//   error            (readback build) sticky readback mismatch, cleared on start
//
// States
//   IDLE   | waiting for start
//   WR_HI  | writing 1 to the PIO, held while waitrequest is high
//   RD_HI  | (readback build) reading the PIO back after the high write
//   GAP_HI | idle gap with the line high
//   WR_LO  | writing 0 to the PIO, held while waitrequest is high
//   RD_LO  | (readback build) reading the PIO back after the low write
//   GAP_LO | idle gap with the line low
//   DONE   | done pulse, then back to IDLE

module pio_clk_pulser_master #(
    parameter int         CNT_W    = 16,
    parameter logic [1:0] PIO_ADDR = 2'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] pulse_count,
    input  logic [CNT_W-1:0] half_period,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulses_left,
    output logic [1:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
`ifdef PIO_PULSER_READBACK_EN
    output logic             avm_read_n,
    input  logic [31:0]      avm_readdata,
    output logic             error,
`endif
    output logic [31:0]      avm_writedata,
    input  logic             avm_waitrequest
);

    typedef enum logic [2:0] {
        IDLE,
        WR_HI,
        GAP_HI,
        WR_LO,
        GAP_LO,
`ifdef PIO_PULSER_READBACK_EN
        RD_HI,
        RD_LO,
`endif
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] pulses_left_q, pulses_left_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic             abort_q, abort_d;
`ifdef PIO_PULSER_READBACK_EN
    logic             error_q, error_d;
    logic             read_n;
`endif

    logic             cs;
    logic             write_n;
    logic             level;
    logic             abort_any;
    logic             hi_accepted;
    logic             lo_accepted;
    logic             lo_last;

    // An abort seen at any point of the train is remembered until IDLE, so a
    // short abort pulse during a stalled write is not lost.
    assign abort_any = abort | abort_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            pulses_left_q <= '0;
            half_q        <= '0;
            gap_q         <= '0;
            abort_q       <= 1'b0;
`ifdef PIO_PULSER_READBACK_EN
            error_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pulses_left_q <= pulses_left_d;
            half_q        <= half_d;
            gap_q         <= gap_d;
            abort_q       <= abort_d;
`ifdef PIO_PULSER_READBACK_EN
            error_q       <= error_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        pulses_left_d = pulses_left_q;
        half_d        = half_q;
        gap_d         = gap_q;
        abort_d       = abort_q | abort;
`ifdef PIO_PULSER_READBACK_EN
        error_d       = error_q;
        read_n        = 1'b1;
`endif
        cs            = 1'b0;
        write_n       = 1'b1;
        level         = 1'b0;
        hi_accepted   = 1'b0;
        lo_accepted   = 1'b0;
        lo_last       = 1'b0;

        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                // abort together with start suppresses the start
                if (start && !abort) begin
                    half_d = half_period;
`ifdef PIO_PULSER_READBACK_EN
                    error_d = 1'b0;
`endif
                    if (pulse_count == '0) begin
                        pulses_left_d = '0;
                        state_d       = DONE;
                    end else begin
                        pulses_left_d = pulse_count;
                        state_d       = WR_HI;
                    end
                end
            end

            WR_HI: begin
                cs      = 1'b1;
                write_n = 1'b0;
                level   = 1'b1;
                if (!avm_waitrequest) begin
`ifdef PIO_PULSER_READBACK_EN
                    state_d = RD_HI;
`else
                    hi_accepted = 1'b1;
`endif
                end
            end

            GAP_HI: begin
                if (abort_any || gap_q <= ONE) begin
                    state_d = WR_LO;
                end else begin
                    gap_d = gap_q - ONE;
                end
            end

            WR_LO: begin
                cs      = 1'b1;
                write_n = 1'b0;
                level   = 1'b0;
                if (!avm_waitrequest) begin
                    // a forced low write on abort does not count as a pulse
                    if (abort_any) begin
                        state_d = DONE;
                    end else begin
                        pulses_left_d = pulses_left_q - ONE;
`ifdef PIO_PULSER_READBACK_EN
                        state_d = RD_LO;
`else
                        lo_accepted = 1'b1;
                        lo_last     = (pulses_left_q == ONE);
`endif
                    end
                end
            end

            GAP_LO: begin
                if (abort_any) begin
                    state_d = DONE;
                end else if (gap_q <= ONE) begin
                    state_d = WR_HI;
                end else begin
                    gap_d = gap_q - ONE;
                end
            end

`ifdef PIO_PULSER_READBACK_EN
            RD_HI: begin
                cs     = 1'b1;
                read_n = 1'b0;
                if (!avm_waitrequest) begin
                    if (!avm_readdata[0]) begin
                        error_d = 1'b1;
                        abort_d = 1'b1;
                        state_d = WR_LO;
                    end else begin
                        hi_accepted = 1'b1;
                    end
                end
            end

            RD_LO: begin
                cs     = 1'b1;
                read_n = 1'b0;
                if (!avm_waitrequest) begin
                    if (avm_readdata[0]) begin
                        error_d = 1'b1;
                        abort_d = 1'b1;
                        state_d = WR_LO;
                    end else begin
                        lo_accepted = 1'b1;
                        lo_last     = (pulses_left_q == '0);
                    end
                end
            end
`endif

            DONE: begin
                abort_d = 1'b0;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase

        // A zero half period skips the gap state so writes go back to back.
        if (hi_accepted) begin
            if (abort_any || half_q == '0) begin
                state_d = WR_LO;
            end else begin
                gap_d   = half_q;
                state_d = GAP_HI;
            end
        end

        if (lo_accepted) begin
            if (lo_last || abort_any) begin
                state_d = DONE;
            end else if (half_q == '0) begin
                state_d = WR_HI;
            end else begin
                gap_d   = half_q;
                state_d = GAP_LO;
            end
        end
    end

    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign pulses_left    = pulses_left_q;
    assign avm_address    = PIO_ADDR;
    assign avm_chipselect = cs;
    assign avm_write_n    = write_n;
    assign avm_writedata  = {31'b0, level};
`ifdef PIO_PULSER_READBACK_EN
    assign avm_read_n     = read_n;
    assign error          = error_q;
`endif

endmodule

// File: doc/pio_clk_pulser_master.md
Name: pio_clk_pulser_master

Overview:
- Avalon-MM write master that drives a single-bit PIO output slave; it is the initiator side of that slave's s1 port.
- Generates a programmed number of software-style clock pulses on the slave's out_port by alternating writes of 1 and 0 to address 0, with a programmable gap after each write.
- Sits between the control logic and a PIO output slave, so pulse trains need no CPU involvement.

Parameters:
- CNT_W, 16, width of pulse_count, half_period and internal counters.
- PIO_ADDR, 0, value driven on avm_address for every transfer.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  level; forces the train to end with the line low.
- pulse_count  in  CNT_W  number of high/low pulses; captured on an accepted start.
- half_period  in  CNT_W  idle cycles after each accepted write; captured on an accepted start.
- busy  out  1  high from the cycle after an accepted start until DONE exits.
- done  out  1  one-cycle pulse when the train completes or is aborted.
- pulses_left  out  CNT_W  remaining pulses (status).
- avm_address  out  2  constant PIO_ADDR.
- avm_chipselect  out  1  transfer strobe.
- avm_write_n  out  1  active-low write.
- avm_writedata  out  32  bit 0 = level, bits 31:1 = 0.
- avm_waitrequest  in  1  slave stall; tie to 0 for a zero-wait PIO.

Behaviour:
- Reset values: avm_chipselect=0, avm_write_n=1, avm_writedata=0, busy=0, done=0, pulses_left=0, state=IDLE. Reset mid-train aborts immediately with no trailing write.
- States are IDLE, WR_HI, GAP_HI, WR_LO, GAP_LO and DONE.
- IDLE: when start=1, capture the inputs.
  - pulse_count=0: go to DONE with no bus activity.
  - Otherwise: go to WR_HI, pulses_left=pulse_count.
- WR_HI and WR_LO:
  - Drive chipselect=1, write_n=0, writedata=1 in WR_HI or 0 in WR_LO.
  - Hold all bus outputs stable while avm_waitrequest=1.
  - A write is accepted in the first cycle with waitrequest=0. With a zero-wait slave the write occupies exactly 1 cycle.
- After WR_HI is accepted: load gap counter = half_period and go to GAP_HI.
- After WR_LO is accepted: decrement pulses_left.
  - If the new value is 0: go to DONE.
  - Otherwise: load gap counter and go to GAP_LO.
- GAP_HI and GAP_LO:
  - Bus idle (chipselect=0, write_n=1).
  - Count down. Exit to the next write (GAP_HI→WR_LO, GAP_LO→WR_HI) when the counter equals 0 on entry or reaches 0.
  - half_period=0 gives back-to-back writes; each gap lasts exactly half_period cycles.
- DONE: done=1 for one cycle, busy=0 next cycle, return to IDLE.
- Throughput with a zero-wait slave: one pulse = 2*(half_period+1) cycles. The out_port high time equals half_period+1 cycles.
- start while not IDLE: ignored; captured values are not disturbed.
- abort:
  - In WR_HI or GAP_HI: once any WR_HI in progress is accepted, go to WR_LO, then DONE (line left low).
  - In GAP_LO: go to DONE.
  - In WR_LO: complete the write, then DONE.
  - abort in IDLE: no effect. abort and start together in IDLE: start is ignored.
- A bus transfer already presented is never withdrawn while waitrequest=1.
- pulse_count of all ones is legal; the counter does not wrap.

Optional Feature:
- Macro: PIO_PULSER_READBACK_EN.
- When defined:
  - Adds ports avm_read_n (out, 1), avm_readdata (in, 32) and error (out, 1, sticky, cleared on accepted start).
  - Adds states RD_HI and RD_LO after each accepted write: chipselect=1, read_n=0 until waitrequest=0, then compare readdata[0] with the written level.
  - A mismatch sets error and goes to DONE via WR_LO (line forced low).
  - Each gap then starts after the read.
- When not defined: no read ports, no read states, avm_read_n absent; timing as above.

Test Plan:
- pulse_count=3, half_period=2, waitrequest=0 -> writes 1,0,1,0,1,0 with 2 idle cycles between them, out_port high 3 cycles per pulse, done 1 cycle after the last write, busy low next cycle.
- pulse_count=0 with start -> no chipselect ever, done pulses 1 cycle after start.
- pulse_count=2, half_period=0, waitrequest high 3 cycles on the first write -> writedata=1 and chipselect held 4 cycles, then back-to-back writes 0,1,0.
- abort asserted in GAP_HI of pulse 2 of 5 -> exactly one write of 0, done, pulses_left=4 at done.
- start asserted while busy with pulse_count=9 -> ignored, original train of 2 completes unchanged. Reset asserted mid-WR_HI -> all bus outputs return to reset values immediately.
- PIO_PULSER_READBACK_EN with readdata[0] stuck at 0 -> first RD_HI mismatches, error=1, one write of 0, done.
